// File: rtl/pc_fetch_unit_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, instruction width and
// the default reset vector used by the PC register.
package mips_defs;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Program counter and retired-instruction counter; both advance together on a
// single load enable, which is the decode handshake.
module pc_register
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [31:0]            i_pc_next,
    output logic [31:0]            o_pc,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [31:0]            r_pc;
    logic [COUNT_WIDTH-1:0] r_count;

    // The counter wraps naturally at 2^COUNT_WIDTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else if (i_load) begin
            r_pc    <= i_pc_next;
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_pc    = r_pc;
    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: fetches from imem over req/ack,
// hands the instruction to decode over valid/ready and closes the next-PC loop.
module pc_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            pc_next,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_out,
    output logic [31:0]            pc_out,
    output logic [31:0]            pc_plus4,
    output logic                   fetch_error,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [INSTR_WIDTH-1:0] r_inst;
    logic                   r_fetch_error;
    logic                   w_fetch_done;
    logic                   w_retire;
    logic                   w_pc_misaligned;
    logic [31:0]            w_pc;

    assign w_fetch_done    = (r_state == FETCH) && imem_ack;
    assign w_retire        = (r_state == VALID) && inst_ready;
    assign w_pc_misaligned = !is_word_aligned(pc_next);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake strobes are pure state decodes so reset removes them at once.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_next = VALID;
                end
            end
            VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    w_state_next = w_pc_misaligned ? ERROR : FETCH;
                end
            end
            ERROR: begin
                w_state_next = ERROR;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inst <= '0;
        end else if (w_fetch_done) begin
            r_inst <= imem_rdata;
        end
    end

    // Sticky until reset; pc keeps the offending value for debug.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_error <= 1'b0;
        end else if (w_retire && w_pc_misaligned) begin
            r_fetch_error <= 1'b1;
        end
    end

    pc_register #(
        .RESET_PC    (RESET_PC),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_pc_register (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_retire),
        .i_pc_next (pc_next),
        .o_pc      (w_pc),
        .o_count   (retired_count)
    );

    assign imem_addr   = w_pc;
    assign pc_out      = w_pc;
    assign pc_plus4    = w_pc + 32'd4;
    assign inst_out    = r_inst;
    assign fetch_error = r_fetch_error;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_pc_fetch_unit;

    localparam int          CW   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   pc_next = '0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [31:0]   inst_out;
    logic [31:0]   pc_out;
    logic [31:0]   pc_plus4;
    logic          fetch_error;
    logic [CW-1:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_unit #(
        .RESET_PC    (RPC),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .fetch_error   (fetch_error),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the unit is either idling after reset, halted on a bad PC,
    // holding an instruction for decode, or waiting on memory.
    bit          m_booting = 1'b1;
    bit          m_halted  = 1'b0;
    bit          m_holding = 1'b0;
    bit          m_err     = 1'b0;
    int unsigned m_retired = 0;
    logic [31:0] m_pc      = RPC;
    logic [31:0] m_inst    = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_booting <= 1'b1;
            m_halted  <= 1'b0;
            m_holding <= 1'b0;
            m_err     <= 1'b0;
            m_retired <= 0;
            m_pc      <= RPC;
            m_inst    <= '0;
        end else if (m_booting) begin
            m_booting <= 1'b0;
        end else if (!m_halted) begin
            if (!m_holding && imem_ack) begin
                m_inst    <= imem_rdata;
                m_holding <= 1'b1;
            end else if (m_holding && inst_ready) begin
                m_retired <= (m_retired + 1) % (1 << CW);
                m_pc      <= pc_next;
                m_holding <= 1'b0;
                if (pc_next % 4 != 0) begin
                    m_halted <= 1'b1;
                    m_err    <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        bit busy_fetch;
        bit offering;
        busy_fetch = !m_booting && !m_halted && !m_holding;
        offering   = !m_booting && !m_halted && m_holding;
        check("model imem_req", {31'd0, imem_req}, {31'd0, busy_fetch});
        check("model inst_valid", {31'd0, inst_valid}, {31'd0, offering});
        check("model pc_out", pc_out, m_pc);
        check("model imem_addr", imem_addr, m_pc);
        check("model pc_plus4", pc_plus4, m_pc + 32'd4);
        check("model inst_out", inst_out, m_inst);
        check("model fetch_error", {31'd0, fetch_error}, {31'd0, m_err});
        check("model retired_count", 32'(retired_count), m_retired);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] r;

        tick();
        tick();
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset pc_out", pc_out, RPC);
        check("reset inst_out", inst_out, 32'd0);
        check("reset fetch_error", {31'd0, fetch_error}, 32'd0);
        check("reset retired_count", 32'(retired_count), 32'd0);

        reset_n = 1'b1;
        check("boot idle req", {31'd0, imem_req}, 32'd0);
        tick();

        // Back-to-back: same-cycle ack, ready high, sequential PCs.
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = $urandom;
            check("seq imem_req", {31'd0, imem_req}, 32'd1);
            check("seq imem_addr", imem_addr, 32'(4 * k));
            tick();
            check("seq inst_valid", {31'd0, inst_valid}, 32'd1);
            pc_next = 32'(4 * k + 4);
            tick();
        end
        check("seq retired_count", 32'(retired_count), 32'd3);

        // Memory takes three extra cycles.
        imem_ack   = 1'b0;
        imem_rdata = 32'h8C01_0004;
        for (int i = 0; i < 3; i++) begin
            check("slow req held", {31'd0, imem_req}, 32'd1);
            check("slow addr held", imem_addr, 32'h0000_000C);
            tick();
        end
        imem_ack = 1'b1;
        check("slow req held", {31'd0, imem_req}, 32'd1);
        tick();
        imem_ack = 1'b0;
        check("slow inst_valid", {31'd0, inst_valid}, 32'd1);
        check("slow inst_out", inst_out, 32'h8C01_0004);

        // Decode stalls while pc_next wanders.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_next = (i % 2 == 1) ? 32'h80 : 32'h40;
            tick();
            check("stall inst_valid", {31'd0, inst_valid}, 32'd1);
            check("stall inst_out", inst_out, 32'h8C01_0004);
            check("stall pc_out", pc_out, 32'h0000_000C);
            check("stall pc_plus4", pc_plus4, 32'h0000_0010);
        end
        inst_ready = 1'b1;
        pc_next    = 32'h100;
        tick();
        inst_ready = 1'b0;
        check("stall next addr", imem_addr, 32'h0000_0100);
        check("stall next req", {31'd0, imem_req}, 32'd1);

        // PC at the top of the address space.
        imem_ack = 1'b1;
        tick();
        inst_ready = 1'b1;
        pc_next    = 32'hFFFF_FFFC;
        tick();
        check("top pc_out", pc_out, 32'hFFFF_FFFC);
        check("top pc_plus4", pc_plus4, 32'h0000_0000);
        pc_next = 32'h0;
        tick();
        tick();
        check("pre-wrap retired_count", 32'(retired_count), 32'd6);

        for (int i = 0; i < 10; i++) begin
            imem_rdata = $urandom;
            pc_next    = 32'h200 + 32'(4 * i);
            tick();
            tick();
        end
        check("wrap retired_count", 32'(retired_count), 32'd0);

        // Reset with an ack still outstanding.
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        tick();
        check("prereset req", {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async req drop", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        tick();
        reset_n = 1'b1;
        check("boot req", {31'd0, imem_req}, 32'd0);
        tick();
        check("boot ack ignored", {31'd0, imem_req}, 32'd1);
        check("after boot addr", imem_addr, RPC);
        check("after boot inst_out", inst_out, 32'd0);

        // Misaligned next PC halts the unit.
        tick();
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pc_next    = 32'h102;
        tick();
        check("err flag", {31'd0, fetch_error}, 32'd1);
        check("err pc held", pc_out, 32'h0000_0102);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            pc_next  = $urandom;
            tick();
            check("err imem_req", {31'd0, imem_req}, 32'd0);
            check("err inst_valid", {31'd0, inst_valid}, 32'd0);
            check("err sticky", {31'd0, fetch_error}, 32'd1);
        end
        reset_n = 1'b0;
        #1;
        check("err cleared", {31'd0, fetch_error}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reset while an instruction is offered.
        imem_ack   = 1'b1;
        inst_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("hold inst_valid", {31'd0, inst_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async valid drop", {31'd0, inst_valid}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            r          = $urandom;
            imem_ack   = ($urandom_range(0, 2) == 0);
            inst_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            pc_next    = {r[31:2], ($urandom_range(0, 39) == 0) ? 2'b10 : 2'b00};
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
